// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter: FSM state encoding,
// byte width and statistics counter widths.
package uart_arb_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned STAT_PKT_W  = 16;
    localparam int unsigned STAT_BYTE_W = 24;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSend   = 2'd1,
        StWaitLo = 2'd2,
        StWaitHi = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after
// rr_ptr, wrapping at N_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Outer loop walks the scan order, inner loop keeps every index a constant.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!any && req_valid[j] && (((32'(rr_ptr) + i) % N_REQ) == j)) begin
                    idx = IDX_W'(j);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding a single uart_tx byte transmitter.
// Define UART_ARB_STATS_EN to add per-requester packet and total byte counters.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_write,
    input  logic                      tx_ready,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o
`ifdef UART_ARB_STATS_EN
    ,
    output logic [STAT_PKT_W*N_REQ-1:0] stat_pkts,
    output logic [STAT_BYTE_W-1:0]      stat_bytes
`endif
);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic              last_q;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  grant_vec;
    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic              accept;
    logic              pkt_done;
    logic [IDX_W-1:0]  ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    // Owner-side mux built from a decoded grant so no variable index is needed.
    always_comb begin
        grant_vec  = '0;
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_vec[i] = (grant_q == IDX_W'(i));
            if (grant_vec[i]) begin
                owner_data = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign owner_valid = |(req_valid & grant_vec);
    assign owner_last  = |(req_last & grant_vec);
    assign accept      = (state_q == StSend) && owner_valid && tx_ready;
    assign pkt_done    = (state_q == StWaitHi) && tx_ready && last_q;
    assign ptr_next    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    assign req_ready = ((state_q == StSend) && tx_ready) ? (req_valid & grant_vec) : '0;
    assign busy_o    = (state_q != StIdle);
    assign grant_o   = busy_o ? grant_vec : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            last_q   <= 1'b0;
            tx_data  <= '0;
            tx_write <= 1'b0;
        end else begin
            tx_write <= accept;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (accept) begin
                        tx_data <= owner_data;
                        last_q  <= owner_last;
                        state_q <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (!tx_ready) begin
                        state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (tx_ready) begin
                        if (last_q) begin
                            rr_ptr_q <= ptr_next;
                            grant_q  <= '0;
                            state_q  <= StIdle;
                        end else begin
                            state_q <= StSend;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [STAT_PKT_W-1:0] pkts_q [N_REQ];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                pkts_q[i] <= '0;
            end
            stat_bytes <= '0;
        end else begin
            if (pkt_done) begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (grant_vec[i]) begin
                        pkts_q[i] <= pkts_q[i] + STAT_PKT_W'(1);
                    end
                end
            end
            if (accept) begin
                stat_bytes <= stat_bytes + STAT_BYTE_W'(1);
            end
        end
    end

    always_comb begin
        stat_pkts = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            stat_pkts[i*STAT_PKT_W +: STAT_PKT_W] = pkts_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with two requesters and a uart_tx model.
// Stats checks are compiled in when UART_ARB_STATS_EN is defined.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned FRAME = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [8*N_REQ-1:0]   req_data = '0;
    logic [N_REQ-1:0]     req_last = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [7:0]           tx_data;
    logic                 tx_write;
    logic                 tx_ready;
    logic [N_REQ-1:0]     grant_o;
    logic                 busy_o;
`ifdef UART_ARB_STATS_EN
    logic [16*N_REQ-1:0]  stat_pkts;
    logic [23:0]          stat_bytes;
`endif

    uart_tx_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_write  (tx_write),
        .tx_ready  (tx_ready),
        .grant_o   (grant_o),
        .busy_o    (busy_o)
`ifdef UART_ARB_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_bytes(stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx model: goes busy on the edge after a write strobe for FRAME cycles.
    int   uart_cnt = 0;
    logic tx_hold = 1'b0;
    always @(posedge clk) begin
        if (tx_write) uart_cnt <= FRAME;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_ready = (uart_cnt == 0) && !tx_hold;

    // Requester packet queues: {last, data}; hold forces valid low.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       hold0 = 1'b0;
    logic       hold1 = 1'b0;
    logic [8:0] exp_q[$];

    initial begin
        logic a0, a1;
        forever begin
            @(negedge clk);
            a0 = req_ready[0];
            a1 = req_ready[1];
            @(posedge clk);
            #2;
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            req_valid[0]   = (q0.size() > 0) && !hold0;
            req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
            req_valid[1]   = (q1.size() > 0) && !hold1;
            req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        end
    end

    // Output monitor: every write strobe pops one expected {requester, byte}.
    always @(negedge clk) begin
        if (rst_n && tx_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(tx_data), 32'hffff_ffff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check_eq("tx_data", 32'(tx_data), 32'(e[7:0]));
                check_eq("grant_at_write", 32'(grant_o), e[8] ? 32'h2 : 32'h1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_pkt(input int r, input logic [7:0] b, input logic last);
        if (r == 0) q0.push_back({last, b});
        else q1.push_back({last, b});
        exp_q.push_back({r[0], b});
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) && !busy_o;
        end
        check_eq(tag, 32'(done), 32'h1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int i = 0; i < budget && wr_cnt < target; i++) @(negedge clk);
        check_eq("write_seen", 32'(wr_cnt >= target), 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'h0);
        check_eq({tag, "_grant"}, 32'(grant_o), 32'h0);
        check_eq({tag, "_write"}, 32'(tx_write), 32'h0);
        check_eq({tag, "_data"}, 32'(tx_data), 32'h0);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'h0);
    endtask

    initial begin
        int  w0;
        logic ok;

        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");

        // Single 3-byte packet from requester 0.
        step();
        push_pkt(0, 8'h41, 1'b0);
        push_pkt(0, 8'h42, 1'b0);
        push_pkt(0, 8'h43, 1'b1);
        wait_done("pkt3_done", 400);
        check_eq("pkt3_busy_after", 32'(busy_o), 32'h0);

        // Both requesters valid together: 0, 1, 0 with no interleaving.
        do_reset();
        push_pkt(0, 8'h10, 1'b0);
        push_pkt(0, 8'h11, 1'b1);
        push_pkt(1, 8'h20, 1'b0);
        push_pkt(1, 8'h21, 1'b1);
        push_pkt(0, 8'h30, 1'b0);
        push_pkt(0, 8'h31, 1'b1);
        // Reorder scoreboard to the round-robin order 0,1,0.
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h31});
        wait_done("rr_done", 800);

        // Requester 1 owns and pauses mid-packet while requester 0 waits.
        step();
        w0 = wr_cnt;
        push_pkt(1, 8'h50, 1'b0);
        push_pkt(1, 8'h51, 1'b0);
        push_pkt(1, 8'h52, 1'b1);
        push_pkt(0, 8'h60, 1'b1);
        wait_writes(w0 + 1, 100);
        step();
        hold1 = 1'b1;
        w0 = wr_cnt;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (grant_o !== 2'b10) ok = 1'b0;
        end
        check_eq("pause_grant_held", 32'(ok), 32'h1);
        check_eq("pause_no_write", 32'(wr_cnt - w0), 32'h0);
        step();
        hold1 = 1'b0;
        wait_done("pause_done", 600);

        // tx_ready low at grant blocks acceptance until it rises.
        step();
        tx_hold = 1'b1;
        push_pkt(0, 8'h77, 1'b1);
        w0 = wr_cnt;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (req_ready !== 2'b00 || tx_write !== 1'b0) ok = 1'b0;
        end
        check_eq("blocked_no_ready", 32'(ok), 32'h1);
        check_eq("blocked_grant", 32'(grant_o), 32'h1);
        step();
        tx_hold = 1'b0;
        @(negedge clk);
        check_eq("ready_on_rise", 32'(req_ready), 32'h1);
        check_eq("no_write_at_accept", 32'(tx_write), 32'h0);
        @(negedge clk);
        check_eq("write_after_accept", 32'(tx_write), 32'h1);
        wait_done("blocked_done", 200);

        // Reset while in WAIT_LO abandons the packet and clears rr_ptr.
        step();
        w0 = wr_cnt;
        push_pkt(1, 8'h90, 1'b0);
        q1.push_back({1'b0, 8'h91});
        q1.push_back({1'b1, 8'h92});
        wait_writes(w0 + 1, 100);
        step();
        rst_n = 1'b0;
        q1.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midpkt_reset");
        step();
        rst_n = 1'b1;
        push_pkt(0, 8'hb0, 1'b1);
        push_pkt(1, 8'ha0, 1'b0);
        push_pkt(1, 8'ha1, 1'b1);
        wait_done("post_reset_done", 400);

`ifdef UART_ARB_STATS_EN
        begin
            int len0[5] = '{3, 2, 2, 2, 3};
            int len1[3] = '{3, 3, 2};
            int ord[8]  = '{0, 1, 0, 1, 0, 1, 0, 0};
            int p0 = 0;
            int p1 = 0;
            do_reset();
            for (int k = 0; k < 8; k++) begin
                int r;
                int p;
                int n;
                r = ord[k];
                p = (r == 0) ? p0 : p1;
                n = (r == 0) ? len0[p] : len1[p];
                for (int b = 0; b < n; b++) begin
                    push_pkt(r, 8'(r * 100 + p * 10 + b), b == n - 1);
                end
                if (r == 0) p0++;
                else p1++;
            end
            wait_done("stats_done", 2000);
            check_eq("stat_pkts", 32'(stat_pkts), {16'd3, 16'd5});
            check_eq("stat_bytes", 32'(stat_bytes), 32'd20);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte transmitter between `N_REQ` byte-stream requesters (e.g. KCPSM6 output port, CRC/count status reporter). Each requester presents packets as valid/ready byte streams with a `last` marker; the arbiter grants one requester at a time in round-robin order, holds the grant for a whole packet, and paces bytes into `uart_tx` using its `ready`/`write` handshake. It sits between the requesters and `uart_tx`, in the same `clk` domain.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `IDX_W`, 3, width of requester index/pointer (must satisfy 2^IDX_W >= N_REQ)

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester byte valid
- `req_data`  in  8*N_REQ  per-requester byte, requester i at bits [8i+7:8i]
- `req_last`  in  N_REQ  byte is last of packet
- `req_ready`  out  N_REQ  byte accepted this cycle (one-hot or zero)
- `tx_data`  out  8  byte to `uart_tx`
- `tx_write`  out  1  one-cycle write strobe to `uart_tx`
- `tx_ready`  in  1  `uart_tx` idle/ready
- `grant_o`  out  N_REQ  one-hot current owner, zero when idle
- `busy_o`  out  1  packet in progress

## Operation
- States: IDLE, SEND, WAIT_LO, WAIT_HI.
- IDLE: if any `req_valid`, pick first valid index scanning from `rr_ptr` upward, wrapping at N_REQ; register grant; -> SEND. Else stay.
- SEND: `req_ready[g] = req_valid[g] & tx_ready` (combinational from state/grant). On accept: capture `req_data[g]` into `tx_data`, capture `req_last[g]` into `last_q`; -> WAIT_LO. If owner drops valid, stay in SEND with grant held (no preemption).
- WAIT_LO: stay until `tx_ready == 0`; -> WAIT_HI.
- WAIT_HI: stay until `tx_ready == 1`; then if `last_q`: `rr_ptr <= (g+1) mod N_REQ`, clear grant, -> IDLE; else -> SEND.
- `tx_write` registered: high exactly the cycle after an accept, otherwise low. `tx_data` holds last captured byte between accepts.
- `busy_o = (state != IDLE)`. `grant_o` one-hot of g when busy, else zero.
- Requesters' valid in IDLE does not produce `req_ready`; only SEND accepts.
- Reset values: state IDLE, `rr_ptr` 0, grant 0, `tx_write` 0, `tx_data` 0x00, `last_q` 0, `req_ready` 0, `busy_o` 0.

## Timing
- Valid at IDLE cycle t -> grant visible t+1 -> accept at t+1 (if `tx_ready`) -> `tx_write` at t+2.
- Between bytes of one packet: minimum gap = UART frame time + 2 cycles (WAIT_HI exit, SEND accept).
- Packet boundary: one IDLE cycle between owners; grant never changes mid-packet.
- Reset mid-packet: arbiter returns to IDLE next edge; partial packet is abandoned; byte already in `uart_tx` completes on the wire; no further `tx_write` until new SEND with `tx_ready` high.
- Single requester continuously valid: rotation still returns grant to it after each packet (no starvation, no lockout).
- Single-byte packets (`last` on first byte) legal.

## Configuration
- `UART_ARB_STATS_EN` defined: adds `stat_pkts` (out, 16*N_REQ) per-requester completed-packet counters and `stat_bytes` (out, 24) total accepted-byte counter; increment on WAIT_HI exit with `last_q` and on accept respectively; wrap at max; reset to 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Structure
- Shared package `uart_arb_pkg`: state encoding constants (IDLE=2'd0, SEND=2'd1, WAIT_LO=2'd2, WAIT_HI=2'd3), `BYTE_W=8`, stats widths.
- Sub-module `rr_pick`: combinational round-robin first-valid selector (inputs `req_valid`, `rr_ptr`; outputs index and `any`). FSM, datapath and stats stay in top.

## Test plan
- Reset then requester 0 sends 3-byte packet 0x41,0x42,0x43 (last on 0x43), UART model drops `tx_ready` 1 cycle after write for 20 cycles -> three `tx_write` pulses with those bytes in order, `grant_o`=01 throughout, `busy_o` 0 after last.
- Both requesters valid simultaneously from reset, each 2-byte packets -> req0 packet fully sent, then req1, then req0 (rr_ptr rotation 0->1->0), no interleaving.
- Requester 1 drops valid mid-packet for 50 cycles while requester 0 valid -> grant stays 10, no `tx_write`, resumes when valid returns.
- `tx_ready` held low at grant -> no `req_ready`, no `tx_write` until `tx_ready` rises; then write occurs one cycle after accept.
- Assert `rst_n`=0 in WAIT_LO mid-packet -> next cycle all outputs at reset values; subsequent packet from requester 1 starts cleanly with rr_ptr 0 scan.
- With `UART_ARB_STATS_EN`: 5 packets req0, 3 packets req1 totalling 20 bytes -> `stat_pkts` = {3,5}, `stat_bytes` = 20.
